// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the core-side FPU dispatch slice.
//   - FPU op index encoding (fop_e) and number of ops (FOP_NUM)
//   - dispatcher FSM state encoding (fsm_state_e)
//   - default operand/result and destination-register widths
//   - op_is_legal(): range check of a 4-bit op index against the op count
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int DATA_W   = 32;
  localparam int RD_W     = 5;
  localparam int FOP_NUM  = 10;
  localparam int OP_IDX_W = 4;

  typedef enum logic [OP_IDX_W-1:0] {
    FOP_FADD  = 4'd0,
    FOP_FSUB  = 4'd1,
    FOP_FMUL  = 4'd2,
    FOP_FDIV  = 4'd3,
    FOP_FSQRT = 4'd4,
    FOP_FTOI  = 4'd5,
    FOP_ITOF  = 4'd6,
    FOP_FABS  = 4'd7,
    FOP_FEQ   = 4'd8,
    FOP_FLE   = 4'd9
  } fop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fsm_state_e;

  function automatic logic op_is_legal(input logic [OP_IDX_W-1:0] op, input int op_n);
    return (int'(op) < op_n);
  endfunction

endpackage

// File: rtl/fpu_dispatch_if.sv
// -----------------------------------------------------------------------------
// fpu_dispatch_if
// Bundles the three channels around the FPU dispatcher:
//   request   : req_valid/req_ready, req_op, req_x1, req_x2, req_rd
//   FPU side  : fpu_opcode (one-hot pulse), fpu_x1, fpu_x2, fpu_y, fpu_valid
//   writeback : wb_valid/wb_ready, wb_data, wb_rd, err_illegal, err_timeout
//   status    : busy, dbg_state (current FSM state)
// Modports:
//   slave  - the dispatcher itself
//   master - the surrounding environment (decoder, FPU, writeback stage)
//
// Handshake rule for both req_* and wb_*: a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holding valid keeps its
// payload stable until that edge; ready may depend combinationally on the
// other side (req_ready follows wb_ready while a response is pending).
// fpu_valid is a single-cycle strobe with no back-pressure.
// -----------------------------------------------------------------------------
interface fpu_dispatch_if #(
  parameter int DATA_W = fpu_pkg::DATA_W,
  parameter int OP_N   = fpu_pkg::FOP_NUM,
  parameter int RD_W   = fpu_pkg::RD_W
);
  import fpu_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [OP_IDX_W-1:0]     req_op;
  logic [DATA_W-1:0]       req_x1;
  logic [DATA_W-1:0]       req_x2;
  logic [RD_W-1:0]         req_rd;

  logic [OP_N-1:0]         fpu_opcode;
  logic [DATA_W-1:0]       fpu_x1;
  logic [DATA_W-1:0]       fpu_x2;
  logic [DATA_W-1:0]       fpu_y;
  logic                    fpu_valid;

  logic                    wb_valid;
  logic                    wb_ready;
  logic [DATA_W-1:0]       wb_data;
  logic [RD_W-1:0]         wb_rd;
  logic                    err_illegal;
  logic                    err_timeout;

  logic                    busy;
  fsm_state_e              dbg_state;

  modport slave (
    input  req_valid, req_op, req_x1, req_x2, req_rd,
    input  fpu_y, fpu_valid,
    input  wb_ready,
    output req_ready,
    output fpu_opcode, fpu_x1, fpu_x2,
    output wb_valid, wb_data, wb_rd, err_illegal, err_timeout,
    output busy, dbg_state
  );

  modport master (
    output req_valid, req_op, req_x1, req_x2, req_rd,
    output fpu_y, fpu_valid,
    output wb_ready,
    input  req_ready,
    input  fpu_opcode, fpu_x1, fpu_x2,
    input  wb_valid, wb_data, wb_rd, err_illegal, err_timeout,
    input  busy, dbg_state
  );

endinterface

// File: rtl/fpu_op_decode.sv
// -----------------------------------------------------------------------------
// fpu_op_decode
// Combinational op-index decoder.
//   op_i     : 4-bit FPU op index
//   onehot_o : OP_N-bit one-hot vector (all zero for an out-of-range index)
//   legal_o  : high when op_i < OP_N
// -----------------------------------------------------------------------------
module fpu_op_decode
  import fpu_pkg::*;
#(
  parameter int OP_N = FOP_NUM
) (
  input  logic [OP_IDX_W-1:0] op_i,
  output logic [OP_N-1:0]     onehot_o,
  output logic                legal_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < OP_N; i++) begin
      onehot_o[i] = (int'(op_i) == i);
    end
    legal_o = op_is_legal(op_i, OP_N);
  end

endmodule

// File: rtl/fpu_dispatch.sv
// -----------------------------------------------------------------------------
// fpu_dispatch
// Core-side initiator for the FPU. Accepts one decoded FP instruction per
// request handshake, holds its operands on fpu_x1/fpu_x2, fires a one-cycle
// one-hot opcode pulse, waits (bounded by TIMEOUT) for fpu_valid and hands the
// result plus destination register to writeback.
// Ports:
//   sys_clk : clock
//   rst     : asynchronous, active-high reset
//   bus     : fpu_dispatch_if.slave (request, FPU and writeback channels,
//             busy and dbg_state status)
// -----------------------------------------------------------------------------
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int DATA_W  = fpu_pkg::DATA_W,
  parameter int OP_N    = FOP_NUM,
  parameter int RD_W    = fpu_pkg::RD_W,
  parameter int TIMEOUT = 64
) (
  input  logic            sys_clk,
  input  logic            rst,
  fpu_dispatch_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fsm_state_e        state_q, state_d;
  logic [OP_N-1:0]   onehot_q, onehot_d;
  logic [DATA_W-1:0] x1_q, x1_d;
  logic [DATA_W-1:0] x2_q, x2_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              ill_q, ill_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [OP_N-1:0]   dec_onehot;
  logic              dec_legal;
  logic              req_ready;
  logic              accept;

  fpu_op_decode #(.OP_N(OP_N)) u_dec (
    .op_i     (bus.req_op),
    .onehot_o (dec_onehot),
    .legal_o  (dec_legal)
  );

  // Accepting while the current response retires lets ops run back to back.
  assign req_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & bus.wb_ready);
  assign accept    = bus.req_valid & req_ready;

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    data_d   = data_q;
    rd_d     = rd_q;
    ill_d    = ill_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;

    if (accept) begin
      // Only reachable from IDLE or a retiring RESP.
      x1_d     = bus.req_x1;
      x2_d     = bus.req_x2;
      rd_d     = bus.req_rd;
      onehot_d = dec_onehot;
      tmo_d    = 1'b0;
      cnt_d    = '0;
      if (dec_legal) begin
        state_d = ST_ISSUE;
        ill_d   = 1'b0;
      end else begin
        state_d = ST_RESP;
        ill_d   = 1'b1;
        data_d  = '0;
      end
    end else begin
      unique case (state_q)
        ST_ISSUE: begin
          if (bus.fpu_valid) begin
            data_d  = bus.fpu_y;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (bus.fpu_valid) begin
            data_d  = bus.fpu_y;
            state_d = ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            data_d  = '0;
            tmo_d   = 1'b1;
            state_d = ST_RESP;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          // fpu_valid here is a stale result and must not touch wb_data.
          if (bus.wb_ready) begin
            state_d = ST_IDLE;
            ill_d   = 1'b0;
            tmo_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      onehot_q <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      data_q   <= '0;
      rd_q     <= '0;
      ill_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      ill_q    <= ill_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  // The pulse is gated by state so it lasts exactly the ISSUE cycle.
  assign bus.fpu_opcode  = (state_q == ST_ISSUE) ? onehot_q : '0;
  assign bus.fpu_x1      = x1_q;
  assign bus.fpu_x2      = x2_q;
  assign bus.req_ready   = req_ready;
  assign bus.wb_valid    = (state_q == ST_RESP);
  assign bus.wb_data     = data_q;
  assign bus.wb_rd       = rd_q;
  assign bus.err_illegal = ill_q;
  assign bus.err_timeout = tmo_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// -----------------------------------------------------------------------------
// tb_fpu_dispatch
// Directed bench for fpu_dispatch. Inputs change and outputs are sampled on the
// falling edge of sys_clk; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_fpu_dispatch;
  import fpu_pkg::*;

  logic sys_clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fpu_dispatch_if #(.DATA_W(32), .OP_N(10), .RD_W(5)) bus ();

  fpu_dispatch #(.DATA_W(32), .OP_N(10), .RD_W(5), .TIMEOUT(64)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Driver tasks
  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [31:0] x1,
                           input logic [31:0] x2, input logic [4:0] rd);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x1    = x1;
    bus.req_x2    = x2;
    bus.req_rd    = rd;
  endtask

  task automatic fpu_strobe(input logic [31:0] y);
    bus.fpu_valid = 1'b1;
    bus.fpu_y     = y;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.fpu_valid = 1'b0;
    bus.wb_ready  = 1'b0;
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [4:0] rd,
                          input logic ill, input logic tmo);
    logic [31:0] exp_data;
    exp_data = exp_q.pop_front();
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, "_wb_data"},  bus.wb_data, exp_data);
    chk({tag, "_wb_rd"},    32'(bus.wb_rd), 32'(rd));
    chk({tag, "_err_ill"},  32'(bus.err_illegal), 32'(ill));
    chk({tag, "_err_tmo"},  32'(bus.err_timeout), 32'(tmo));
  endtask

  // Hand the pending response to writeback and return to IDLE.
  task automatic retire(input string tag);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk({tag, "_retired_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, "_retired_busy"},     32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_x1    = '0;
    bus.req_x2    = '0;
    bus.req_rd    = '0;
    bus.fpu_valid = 1'b0;
    bus.fpu_y     = '0;
    bus.wb_ready  = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_opcode",   32'(bus.fpu_opcode), 32'd0);
    chk("rst_x1",       bus.fpu_x1, 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_data",  bus.wb_data, 32'd0);
    chk("rst_busy",     32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // ---- fadd, FPU latency 3 ----
    drive_req(FOP_FADD, 32'h3F800000, 32'h40000000, 5'd5);
    exp_q.push_back(32'h40400000);
    tick();                                   // ISSUE cycle
    idle_inputs();
    chk("fadd_opcode", 32'(bus.fpu_opcode), 32'h001);
    chk("fadd_x1",     bus.fpu_x1, 32'h3F800000);
    chk("fadd_x2",     bus.fpu_x2, 32'h40000000);
    chk("fadd_busy",   32'(bus.busy), 32'd1);
    chk("fadd_req_ready_busy", 32'(bus.req_ready), 32'd0);
    tick();
    chk("fadd_pulse_one_cycle", 32'(bus.fpu_opcode), 32'd0);
    chk("fadd_state_wait", 32'(bus.dbg_state), 32'(ST_WAIT));
    tick();
    tick();                                   // 3 cycles after the pulse
    fpu_strobe(32'h40400000);
    chk("fadd_no_early_wb", 32'(bus.wb_valid), 32'd0);
    tick();                                   // 5 cycles after accept
    idle_inputs();
    chk_resp("fadd", 5'd5, 1'b0, 1'b0);
    retire("fadd");

    // ---- fle, FPU latency 0 ----
    drive_req(FOP_FLE, 32'h1, 32'h2, 5'd3);
    exp_q.push_back(32'h1);
    tick();
    idle_inputs();
    chk("fle_opcode", 32'(bus.fpu_opcode), 32'h200);
    fpu_strobe(32'h1);
    tick();                                   // 2 cycles after accept
    idle_inputs();
    chk_resp("fle", 5'd3, 1'b0, 1'b0);
    retire("fle");

    // ---- illegal op ----
    drive_req(4'd12, 32'hAAAA5555, 32'h5555AAAA, 5'd7);
    exp_q.push_back(32'h0);
    tick();
    idle_inputs();
    chk("ill_opcode", 32'(bus.fpu_opcode), 32'd0);
    chk_resp("ill", 5'd7, 1'b1, 1'b0);
    retire("ill");

    // ---- timeout, FPU never answers ----
    drive_req(FOP_FDIV, 32'h12345678, 32'h9ABCDEF0, 5'd9);
    exp_q.push_back(32'h0);
    tick();                                   // ISSUE cycle
    idle_inputs();
    chk("tmo_opcode", 32'(bus.fpu_opcode), 32'h008);
    repeat (63) tick();
    chk("tmo_not_yet", 32'(bus.wb_valid), 32'd0);
    chk("tmo_x1_held", bus.fpu_x1, 32'h12345678);
    tick();                                   // 64 cycles after ISSUE
    chk_resp("tmo", 5'd9, 1'b0, 1'b1);
    fpu_strobe(32'hDEADBEEF);                 // late result
    tick();
    idle_inputs();
    exp_q.push_back(32'h0);
    chk_resp("tmo_late", 5'd9, 1'b0, 1'b1);
    retire("tmo");

    // ---- back-pressure then back-to-back accept ----
    drive_req(FOP_FMUL, 32'h40000000, 32'h40400000, 5'd11);
    exp_q.push_back(32'h11111111);
    tick();
    idle_inputs();
    chk("bp_opcode", 32'(bus.fpu_opcode), 32'h004);
    tick();
    fpu_strobe(32'h11111111);
    tick();
    idle_inputs();
    drive_req(FOP_FSUB, 32'hC0000000, 32'h3F000000, 5'd12);
    for (int i = 0; i < 10; i++) begin
      chk("bp_wb_data_stable", bus.wb_data, 32'h11111111);
      chk("bp_req_ready_low",  32'(bus.req_ready), 32'd0);
      tick();
    end
    chk_resp("bp", 5'd11, 1'b0, 1'b0);
    bus.wb_ready = 1'b1;
    #1;
    chk("bp_req_ready_follows_wb", 32'(bus.req_ready), 32'd1);
    exp_q.push_back(32'h22222222);
    tick();
    idle_inputs();
    chk("b2b_opcode",   32'(bus.fpu_opcode), 32'h002);
    chk("b2b_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("b2b_x1",       bus.fpu_x1, 32'hC0000000);
    fpu_strobe(32'h22222222);
    tick();
    idle_inputs();
    chk_resp("b2b", 5'd12, 1'b0, 1'b0);
    retire("b2b");

    // ---- reset during WAIT ----
    drive_req(FOP_FDIV, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd20);
    tick();
    idle_inputs();
    tick();
    tick();
    chk("rstw_in_wait", 32'(bus.dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    #1;
    chk("rstw_busy",     32'(bus.busy), 32'd0);
    chk("rstw_x1",       bus.fpu_x1, 32'd0);
    chk("rstw_x2",       bus.fpu_x2, 32'd0);
    chk("rstw_wb_rd",    32'(bus.wb_rd), 32'd0);
    chk("rstw_wb_valid", 32'(bus.wb_valid), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    fpu_strobe(32'h77777777);                 // stale FPU answer
    tick();
    idle_inputs();
    chk("rstw_stale_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rstw_stale_wb_data",  bus.wb_data, 32'd0);

    // ---- fmul after reset, FPU latency 2 ----
    drive_req(FOP_FMUL, 32'h40000000, 32'h40000000, 5'd31);
    exp_q.push_back(32'h40800000);
    tick();
    idle_inputs();
    chk("fmul_opcode", 32'(bus.fpu_opcode), 32'h004);
    tick();
    tick();
    fpu_strobe(32'h40800000);
    tick();
    idle_inputs();
    chk_resp("fmul", 5'd31, 1'b0, 1'b0);
    retire("fmul");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
